// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy count, flags and a small life-cycle FSM
// for an externally attached synchronous storage array.
module fifo_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8,
  parameter int AF_DEF = 6,
  parameter int AE_DEF = 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic [3:0]        af_thr,
  input  logic [3:0]        ae_thr,
  input  logic              push,
  input  logic              pop,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error,
  output logic [2:0]        state
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wp;
  logic [ADDR_W-1:0]   r_rp;
  logic [ADDR_W:0]     r_cnt;
  logic [ADDR_W:0]     w_cnt_nxt;
  logic [3:0]          r_af;
  logic [3:0]          r_ae;
  logic                r_valid;
  logic                w_active;
  logic                w_we;
  logic                w_re;
  logic                w_ovf;
  logic                w_udf;
  logic                w_full;
  logic                w_empty;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Occupancy flags derived purely from the registered count.
  always_comb begin
    w_empty      = (r_cnt == '0);
    w_full       = (r_cnt == CW'(DEPTH));
    almost_full  = (32'(r_cnt) >= 32'(r_af));
    almost_empty = (32'(r_cnt) <= 32'(r_ae));
  end

  // Request acceptance, error detection and next occupancy.
  always_comb begin
    w_active  = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    w_we      = w_active & push & (~w_full | pop);
    w_re      = w_active & pop & ~w_empty;
    w_ovf     = push & w_full & ~pop;
    w_udf     = pop & w_empty;
    w_cnt_nxt = r_cnt;
    if (w_we && !w_re)
      w_cnt_nxt = r_cnt + CW'(1);
    else if (w_re && !w_we)
      w_cnt_nxt = r_cnt - CW'(1);
  end

  // Next-state logic; init overrides everything except the RESET exit.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_RESET) begin
      w_state_nxt = S_INIT;
    end else if (init) begin
      w_state_nxt = S_INIT;
    end else begin
      case (r_state)
        S_INIT:   w_state_nxt = S_IDLE;
        S_IDLE: begin
          if (w_ovf || w_udf)  w_state_nxt = S_ERROR;
          else if (w_we)       w_state_nxt = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (w_ovf || w_udf)        w_state_nxt = S_ERROR;
          else if (w_cnt_nxt == '0)  w_state_nxt = S_IDLE;
        end
        S_ERROR:  w_state_nxt = S_ERROR;
        default:  w_state_nxt = S_RESET;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= S_RESET;
    else          r_state <= w_state_nxt;
  end

  // Pointers and count; cleared whenever the FSM is heading into INIT.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (w_state_nxt == S_INIT) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_we) r_wp <= ptr_inc(r_wp);
      if (w_re) r_rp <= ptr_inc(r_rp);
      r_cnt <= w_cnt_nxt;
    end
  end

  // Threshold latches, transparent only while in INIT.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_af <= 4'(AF_DEF);
      r_ae <= 4'(AE_DEF);
    end else if (r_state == S_INIT) begin
      r_af <= af_thr;
      r_ae <= ae_thr;
    end
  end

  // Read data from storage is registered, so valid trails re by one cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_valid <= 1'b0;
    else          r_valid <= w_re;
  end

  // Output mapping.
  always_comb begin
    we      = w_we;
    re      = w_re;
    wr_addr = r_wp;
    rd_addr = r_rp;
    valid   = r_valid;
    count   = r_cnt;
    full    = w_full;
    empty   = w_empty;
    error   = (r_state == S_ERROR);
    state   = r_state;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: queue-based reference model plus an attached storage array.
module tb_fifo_ctrl;

  localparam int AW = 3;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          init = 1'b0;
  logic [3:0]    af_thr = 4'd6;
  logic [3:0]    ae_thr = 4'd1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          we, re, valid, full, empty, almost_full, almost_empty, error;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   count;
  logic [2:0]    state;
  logic [7:0]    wdata = 8'h00;
  logic [7:0]    rdata;
  logic [7:0]    mem [DP];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int       m_state;
  logic [7:0] m_q[$];
  int       m_wp, m_rp, m_af, m_ae;
  bit       m_valid;
  logic [7:0] m_exp;

  fifo_ctrl #(.ADDR_W(AW), .DEPTH(DP), .AF_DEF(6), .AE_DEF(1)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .af_thr(af_thr), .ae_thr(ae_thr),
    .push(push), .pop(pop), .we(we), .re(re), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .valid(valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[wr_addr] <= wdata;
    if (re) rdata <= mem[rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_q.delete(); m_wp = 0; m_rp = 0;
    m_af = 6; m_ae = 1; m_valid = 0; m_exp = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_we"},    32'(we), 0);
    chk({tag, "_re"},    32'(re), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_wa"},    32'(wr_addr), 0);
    chk({tag, "_ra"},    32'(rd_addr), 0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit ps, input bit pp, input bit in, input int af, input int ae);
    int  cnt, ns;
    bit  act, mfull, mempty, ewe, ere;
    push = ps; pop = pp; init = in;
    af_thr = 4'(af); ae_thr = 4'(ae);
    wdata = 8'($urandom);
    #1;
    cnt = m_q.size();
    act = (m_state == 2) || (m_state == 3);
    mfull = (cnt == DP); mempty = (cnt == 0);
    ewe = act && ps && (!mfull || pp);
    ere = act && pp && !mempty;
    chk("state", 32'(state), 32'(m_state));
    chk("count", 32'(count), 32'(cnt));
    chk("wr_addr", 32'(wr_addr), 32'(m_wp));
    chk("rd_addr", 32'(rd_addr), 32'(m_rp));
    chk("full", 32'(full), 32'(mfull));
    chk("empty", 32'(empty), 32'(mempty));
    chk("almost_full", 32'(almost_full), 32'(cnt >= m_af));
    chk("almost_empty", 32'(almost_empty), 32'(cnt <= m_ae));
    chk("error", 32'(error), 32'(m_state == 4));
    chk("we", 32'(we), 32'(ewe));
    chk("re", 32'(re), 32'(ere));
    chk("valid", 32'(valid), 32'(m_valid));
    if (m_valid) chk("rdata", 32'(rdata), 32'(m_exp));

    if (m_state == 0) ns = 1;
    else if (in) ns = 1;
    else if (m_state == 1) ns = 2;
    else if (act && ((ps && mfull && !pp) || (pp && mempty))) ns = 4;
    else ns = m_state;
    if (ere) begin m_exp = m_q.pop_front(); m_rp = (m_rp + 1) % DP; end
    if (ewe) begin m_q.push_back(wdata); m_wp = (m_wp + 1) % DP; end
    if (ns == 2 && m_state == 2 && ewe) ns = 3;
    if (ns == 3 && m_state == 3 && m_q.size() == 0) ns = 2;
    if (m_state == 1) begin m_af = af; m_ae = ae; end
    if (ns == 1) begin m_q.delete(); m_wp = 0; m_rp = 0; end
    m_valid = ere;
    m_state = ns;
    @(negedge clk);
  endtask

  initial begin
    bit ps, pp, in;
    m_reset();
    reset_L = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_almost_empty", 32'(almost_empty), 1);
    chk("reset_almost_full", 32'(almost_full), 0);
    @(negedge clk);
    reset_L = 1'b1;

    // init held two cycles with new thresholds, then five pushes
    step(0, 0, 1, 5, 2);
    step(0, 0, 1, 5, 2);
    step(0, 0, 0, 5, 2);
    repeat (5) step(1, 0, 0, 5, 2);
    #1;
    chk("dir_count5", 32'(count), 5);
    chk("dir_af5", 32'(almost_full), 1);
    chk("dir_ae5", 32'(almost_empty), 0);
    chk("dir_active", 32'(state), 3);
    #1;
    // fill, simultaneous push+pop at full, drain across the wrap
    repeat (3) step(1, 0, 0, 5, 2);
    step(1, 1, 0, 5, 2);
    repeat (8) step(0, 1, 0, 5, 2);
    step(0, 0, 0, 5, 2);
    // overflow, linger in ERROR, recover via init
    repeat (8) step(1, 0, 0, 5, 2);
    step(1, 0, 0, 5, 2);
    step(1, 0, 0, 5, 2);
    step(0, 0, 1, 5, 2);
    step(0, 0, 0, 5, 2);
    // push+pop on an empty FIFO is an underflow
    step(1, 1, 0, 5, 2);
    step(0, 0, 0, 5, 2);
    step(0, 0, 1, 6, 1);
    step(0, 0, 0, 6, 1);
    // asynchronous reset in the middle of a transfer
    repeat (3) step(1, 0, 0, 6, 1);
    push = 1'b0; pop = 1'b1; init = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    reset_L = 1'b1;
    m_reset();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      ps = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      in = ($urandom_range(0, 39) == 0) || (m_state == 4 && $urandom_range(0, 3) == 0);
      step(ps, pp, in, int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
